// File: rtl/pipeline_unit.sv
// Two-stage signed multiply-accumulate: y_out = y_in + x_in*w_in.
// Define PIPELINE_UNIT_SAT_EN to clamp the result instead of wrapping.
module pipeline_unit #(
  parameter int DATA_W = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic signed [DATA_W-1:0] y_in,
  output logic signed [DATA_W-1:0] y_out
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = 2 * DATA_W + 1;

  logic signed [PW-1:0]     prod_d;
  logic signed [PW-1:0]     prod_q;
  logic signed [DATA_W-1:0] yin_q;
  logic signed [DATA_W-1:0] y_d;
  logic signed [DATA_W-1:0] y_q;

  assign prod_d = PW'(x_in) * PW'(w_in);

`ifdef PIPELINE_UNIT_SAT_EN
  localparam logic signed [SW-1:0] MAXV =
    SW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic signed [SW-1:0] sum_d;

  // Clamp decision looks only at the full-width sum.
  always_comb begin
    sum_d = SW'(prod_q) + SW'(yin_q);
    y_d   = sum_d[DATA_W-1:0];
    if (sum_d > MAXV) begin
      y_d = MAXV[DATA_W-1:0];
    end else if (sum_d < MINV) begin
      y_d = MINV[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    y_d = DATA_W'(SW'(prod_q) + SW'(yin_q));
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      yin_q  <= '0;
      y_q    <= '0;
    end else begin
      prod_q <= prod_d;
      yin_q  <= y_in;
      y_q    <= y_d;
    end
  end

  assign y_out = y_q;

endmodule

// File: tb/tb_pipeline_unit.sv
// Scoreboard bench for pipeline_unit: driver pushes expected results,
// a negedge monitor pops and compares them two edges later.
module tb_pipeline_unit;

  localparam int W = 17;

  logic                clk;
  logic                rst;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] w_in;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] y_out;

  typedef struct {
    int         cyc;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  pipeline_unit #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .x_in  (x_in),
    .w_in  (w_in),
    .y_in  (y_in),
    .y_out (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(
    input logic signed [W-1:0] x,
    input logic signed [W-1:0] w,
    input logic signed [W-1:0] y
  );
    longint s;
    longint hi;
    longint lo;
    logic [63:0] u;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    s  = longint'(y) + longint'(x) * longint'(w);
`ifdef PIPELINE_UNIT_SAT_EN
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`endif
    u = 64'(s);
    return u[W-1:0];
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc   = cyc + 1;
    e.cyc = cyc;
    e.val = rst ? model(x_in, w_in, y_in) : '0;
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      n_vec = n_vec + 1;
      if (y_out !== '0) begin
        n_err = n_err + 1;
        $display("FAIL reset_zero: y_out=%h want=0", y_out);
      end
      sb.delete();
    end else if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
      e = sb.pop_front();
      n_vec = n_vec + 1;
      if (y_out !== e.val) begin
        n_err = n_err + 1;
        $display("FAIL result cyc%0d: y_out=%h want=%h",
                 e.cyc, y_out, e.val);
      end
    end
  end

  task automatic drive(input logic [W-1:0] x,
                       input logic [W-1:0] w,
                       input logic [W-1:0] y);
    @(posedge clk);
    #3;
    x_in = x;
    w_in = w;
    y_in = y;
  endtask

  function automatic logic [W-1:0] pick();
    int r;
    r = $urandom_range(0, 5);
    case (r)
      0:       return 17'h0FFFF;
      1:       return 17'h10000;
      2:       return 17'($urandom_range(0, 7));
      default: return 17'($urandom);
    endcase
  endfunction

  initial begin
    cyc   = 0;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    x_in  = 17'h00123;
    w_in  = 17'h00045;
    y_in  = 17'h00678;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;

    drive(17'd2, 17'd4, 17'd1);
    drive(-17'sd1, -17'sd1, -17'sd1);
    drive(17'd2, 17'd4, -17'sd1);
    drive(-17'sd2, 17'd4, 17'd1);
    drive(17'd2, -17'sd2, 17'd1);
    drive(17'h0FFFF, 17'd2, 17'd0);
    drive(17'h0FFFF, 17'h0FFFF, 17'h0FFFF);
    drive(17'h10000, 17'h0FFFF, 17'h10000);
    drive(17'h10000, 17'h10000, 17'h10000);
    drive(17'h10000, 17'd1, 17'h1FFFF);
    drive(17'h0FFFF, 17'd1, 17'd1);

    for (int i = 0; i < 200; i++) begin
      drive(pick(), pick(), pick());
    end

    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;

    for (int i = 0; i < 200; i++) begin
      drive(pick(), pick(), pick());
    end

    repeat (4) @(posedge clk);
    #2;
    if (sb.size() > 0 && sb[0].cyc < cyc - 1) begin
      n_err = n_err + 1;
      $display("FAIL drain: stale cyc=%0d want>=%0d",
               sb[0].cyc, cyc - 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_unit.md
PIPELINE_UNIT -- requirements
Module: pipeline_unit

Interface
REQ-001 Parameter DATA_W, default 17: width of every data port; all data values are two's-complement signed.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- x_in, input, DATA_W: signed multiplicand (systolic input sample).
- w_in, input, DATA_W: signed multiplier (weight).
- y_in, input, DATA_W: signed partial sum to accumulate.
- y_out, output, DATA_W: registered signed result.
REQ-003 The block SHALL have one clock domain and no other ports.

Function
REQ-004 Result SHALL be y_out = clamp(y_in + x_in*w_in) over a two-stage pipeline.
REQ-005 Stage 1 SHALL register the full-precision signed product x_in*w_in (2*DATA_W bits) and y_in each rising clk edge.
REQ-006 Stage 2 SHALL register a sum computed at 2*DATA_W+1 bits, so no intermediate overflow can occur.
REQ-007 Latency SHALL be exactly 2 clk edges: inputs sampled at edge N appear on y_out after edge N+1.
REQ-008 Throughput SHALL be one new operand set per clock, with no stalls and no handshake.
REQ-009 With saturation enabled, sums above 2^(DATA_W-1)-1 SHALL give 2^(DATA_W-1)-1 (0x0FFFF for 17 bits).
REQ-010 With saturation enabled, sums below -2^(DATA_W-1) SHALL give -2^(DATA_W-1) (0x10000 for 17 bits).
REQ-011 In-range sums SHALL pass through exactly, including negative results and sign changes.
REQ-012 y_out SHALL be driven directly from a register, with no combinational path from inputs to output.
REQ-013 Overflow determination SHALL use only the wide sum; the product alone overflowing SHALL NOT matter if the final sum is in range.

Reset
REQ-014 While rst=0, both pipeline stages and y_out SHALL be 0, asynchronously and independent of clk.
REQ-015 Reset asserted mid-operation SHALL discard all in-flight results.
REQ-016 After rst rises, the first valid result SHALL appear two edges later; until then y_out SHALL stay 0.

Configuration
REQ-017 Macro PIPELINE_UNIT_SAT_EN defined: the clamp of REQ-009/REQ-010 SHALL be compiled in.
REQ-018 Macro PIPELINE_UNIT_SAT_EN undefined: y_out SHALL be the low DATA_W bits of the wide sum (two's-complement wrap), with no clamp logic.
REQ-019 Latency and reset behaviour SHALL be identical in both builds.

Verification (DATA_W=17, PIPELINE_UNIT_SAT_EN defined unless noted; check y_out 2 edges after input)
REQ-020 Reset: hold rst=0 with nonzero inputs, then release -> y_out=0 during reset and for 2 edges after release.
REQ-021 Basic and signed cases:
- y=1, x=2, w=4 -> 9
- y=-1, x=-1, w=-1 -> 0
- y=-1, x=2, w=4 -> 7
- y=1, x=-2, w=4 -> -7
- y=1, x=2, w=-2 -> -3
REQ-022 Positive saturation:
- y=0, x=0x0FFFF, w=2 -> 0x0FFFF
- y=x=w=0x0FFFF -> 0x0FFFF
REQ-023 Negative saturation: y=0x10000, x=0x10000, w=0x0FFFF -> 0x10000.
REQ-024 Back-to-back: apply a new vector every cycle -> each result appears in order, one per cycle, 2 cycles late; assert rst mid-stream -> y_out=0 immediately.
REQ-025 Without PIPELINE_UNIT_SAT_EN: y=0, x=0x0FFFF, w=2 -> 0x1FFFE (wrapped).
